// File: rtl/div_error_monitor.sv
// Error-statistics collector for the 16/8 approximate divider: recomputes the exact
// quotient/remainder with a restoring divider and accumulates quotient error statistics.
module div_error_monitor #(
    parameter int CNT_W  = 32,
    parameter int SKIP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       n,
    input  logic [7:0]        d,
    input  logic [7:0]        q_apx,
    input  logic [7:0]        r_apx,
    input  logic              clear,
    output logic              busy,
    output logic              stat_upd,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  err_sum,
    output logic [7:0]        max_err,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [SKIP_W-1:0] skip_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_ACC
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [SKIP_W-1:0] SKIP_ONE = SKIP_W'(1);

    state_t            state_q, state_d;
    logic [7:0]        pr_q, pr_d;
    logic [7:0]        quo_q, quo_d;
    logic [7:0]        nlo_q, nlo_d;
    logic [7:0]        div_q, div_d;
    logic [7:0]        qa_q, qa_d;
    logic [7:0]        ra_q, ra_d;
    logic [2:0]        iter_q, iter_d;
    logic              stat_upd_q, stat_upd_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]  err_sum_q, err_sum_d;
    logic [7:0]        max_err_q, max_err_d;
    logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;

    logic              accept;
    logic              in_domain;
    logic [8:0]        shifted;
    logic [8:0]        diff;
    logic [7:0]        q_err;
    logic [CNT_W:0]    err_sum_ext;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = ~in_ready;
    assign accept    = in_valid & in_ready;
    assign in_domain = (d != 8'd0) && (n[15:8] < d);

    // Partial remainder is always below the divisor, so the 9-bit difference
    // has bit 8 set exactly when the trial subtraction borrows.
    assign shifted = {pr_q, nlo_q[7]};
    assign diff    = shifted - {1'b0, div_q};

    assign q_err       = (quo_q >= qa_q) ? (quo_q - qa_q) : (qa_q - quo_q);
    assign err_sum_ext = {1'b0, err_sum_q} + {{(CNT_W + 1 - 8){1'b0}}, q_err};

    always_comb begin
        state_d        = state_q;
        pr_d           = pr_q;
        quo_d          = quo_q;
        nlo_d          = nlo_q;
        div_d          = div_q;
        qa_d           = qa_q;
        ra_d           = ra_q;
        iter_d         = iter_q;
        stat_upd_d     = 1'b0;
        sample_cnt_d   = sample_cnt_q;
        err_sum_d      = err_sum_q;
        max_err_d      = max_err_q;
        mismatch_cnt_d = mismatch_cnt_q;
        skip_cnt_d     = skip_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_domain) begin
                        pr_d    = n[15:8];
                        nlo_d   = n[7:0];
                        div_d   = d;
                        qa_d    = q_apx;
                        ra_d    = r_apx;
                        quo_d   = 8'd0;
                        iter_d  = 3'd0;
                        state_d = S_DIV;
                    end else if (skip_cnt_q != {SKIP_W{1'b1}}) begin
                        skip_cnt_d = skip_cnt_q + SKIP_ONE;
                    end
                end
            end
            S_DIV: begin
                pr_d   = diff[8] ? shifted[7:0] : diff[7:0];
                quo_d  = {quo_q[6:0], ~diff[8]};
                nlo_d  = {nlo_q[6:0], 1'b0};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (sample_cnt_q != {CNT_W{1'b1}}) begin
                    sample_cnt_d = sample_cnt_q + CNT_ONE;
                end
                err_sum_d = err_sum_ext[CNT_W] ? {CNT_W{1'b1}} : err_sum_ext[CNT_W-1:0];
                if (q_err > max_err_q) begin
                    max_err_d = q_err;
                end
                if (((quo_q != qa_q) || (pr_q != ra_q)) && (mismatch_cnt_q != {CNT_W{1'b1}})) begin
                    mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
                end
                stat_upd_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Clear aborts the in-flight sample and wins over any handshake this cycle.
        if (clear) begin
            state_d        = S_IDLE;
            stat_upd_d     = 1'b0;
            sample_cnt_d   = '0;
            err_sum_d      = '0;
            max_err_d      = 8'd0;
            mismatch_cnt_d = '0;
            skip_cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pr_q           <= 8'd0;
            quo_q          <= 8'd0;
            nlo_q          <= 8'd0;
            div_q          <= 8'd0;
            qa_q           <= 8'd0;
            ra_q           <= 8'd0;
            iter_q         <= 3'd0;
            stat_upd_q     <= 1'b0;
            sample_cnt_q   <= '0;
            err_sum_q      <= '0;
            max_err_q      <= 8'd0;
            mismatch_cnt_q <= '0;
            skip_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            pr_q           <= pr_d;
            quo_q          <= quo_d;
            nlo_q          <= nlo_d;
            div_q          <= div_d;
            qa_q           <= qa_d;
            ra_q           <= ra_d;
            iter_q         <= iter_d;
            stat_upd_q     <= stat_upd_d;
            sample_cnt_q   <= sample_cnt_d;
            err_sum_q      <= err_sum_d;
            max_err_q      <= max_err_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            skip_cnt_q     <= skip_cnt_d;
        end
    end

    assign stat_upd     = stat_upd_q;
    assign sample_cnt   = sample_cnt_q;
    assign err_sum      = err_sum_q;
    assign max_err      = max_err_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign skip_cnt     = skip_cnt_q;

endmodule
